// File: rtl/gbt_chk_pkg.sv
// -----------------------------------------------------------------------------
// gbt_chk_pkg
// Shared types and default constants for the GBT receive-side pattern checker.
//   gbt_state_e  : checker FSM states (HUNT, VERIFY, LOCKED)
//   gbt_word_t   : 16-bit GBT receive word
//   *_DEF        : default lock / unlock / burst thresholds
// -----------------------------------------------------------------------------
package gbt_chk_pkg;

  typedef logic [15:0] gbt_word_t;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } gbt_state_e;

  localparam int LOCK_CNT_DEF   = 16;
  localparam int UNLOCK_CNT_DEF = 4;
  localparam int BURST_LEN_DEF  = 256;

endpackage

// File: rtl/gbt_rcv_checker_if.sv
// -----------------------------------------------------------------------------
// gbt_rcv_checker_if
// Bundles the receive words, control strobes and test-point outputs of
// gbt_rcv_checker.
//   slave  modport : checker side (receives RX_*, READ_START, ERR_CLR)
//   master modport : source / test-point side
// Optional FRAME_CNT signal is present only when GBT_RCV_CHK_FRAME_CNT_EN is
// defined.
// Handshake: RX_VLD qualifies RX_DATA on each cycle it is high; there is no
// backpressure, so the checker accepts every qualified word.
// -----------------------------------------------------------------------------
interface gbt_rcv_checker_if #(
  parameter int ERR_W = 16
);
  import gbt_chk_pkg::*;

  gbt_word_t        RX_DATA;
  logic             RX_VLD;
  logic             READ_START;
  logic             ERR_CLR;
  gbt_word_t        GBT_RCV_DATA;
  logic             GBT_RCV_DATA_VLD;
  logic             GBT_RCV_RDY;
  logic             GBT_READ_ENA;
  logic [ERR_W-1:0] ERR_CNT;
  logic             LOCK_LOST;
  logic [1:0]       STATE;       // debug: current FSM state
`ifdef GBT_RCV_CHK_FRAME_CNT_EN
  logic [31:0]      FRAME_CNT;

  modport slave (
    input  RX_DATA, RX_VLD, READ_START, ERR_CLR,
    output GBT_RCV_DATA, GBT_RCV_DATA_VLD, GBT_RCV_RDY, GBT_READ_ENA,
           ERR_CNT, LOCK_LOST, STATE, FRAME_CNT
  );
  modport master (
    output RX_DATA, RX_VLD, READ_START, ERR_CLR,
    input  GBT_RCV_DATA, GBT_RCV_DATA_VLD, GBT_RCV_RDY, GBT_READ_ENA,
           ERR_CNT, LOCK_LOST, STATE, FRAME_CNT
  );
`else
  modport slave (
    input  RX_DATA, RX_VLD, READ_START, ERR_CLR,
    output GBT_RCV_DATA, GBT_RCV_DATA_VLD, GBT_RCV_RDY, GBT_READ_ENA,
           ERR_CNT, LOCK_LOST, STATE
  );
  modport master (
    output RX_DATA, RX_VLD, READ_START, ERR_CLR,
    input  GBT_RCV_DATA, GBT_RCV_DATA_VLD, GBT_RCV_RDY, GBT_READ_ENA,
           ERR_CNT, LOCK_LOST, STATE
  );
`endif

endinterface

// File: rtl/gbt_rd_burst.sv
// -----------------------------------------------------------------------------
// gbt_rd_burst
// Read-burst window generator.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_rdy          : registered ready (lock) as seen on the test point
//   i_lock_nxt     : lock state being registered this cycle
//   i_read_start   : single-cycle burst request
//   i_rx_vld       : receive word qualifier
//   o_read_ena     : registered (burst active AND RX_VLD)
// A burst covers BURST_LEN valid words, starting with the first valid word
// after the arming cycle.
// -----------------------------------------------------------------------------
module gbt_rd_burst #(
  parameter int BURST_LEN = 256
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_rdy,
  input  logic i_lock_nxt,
  input  logic i_read_start,
  input  logic i_rx_vld,
  output logic o_read_ena
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

  logic             r_active;
  logic [CNT_W-1:0] r_cnt;
  logic             r_read_ena;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_active   <= 1'b0;
      r_cnt      <= '0;
      r_read_ena <= 1'b0;
    end else begin
      // Gating with the next lock state drops READ_ENA on the same edge that
      // drops RDY when lock is lost.
      r_read_ena <= r_active & i_rx_vld & i_lock_nxt;
      if (!i_lock_nxt) begin
        r_active <= 1'b0;
        r_cnt    <= '0;
      end else if (r_active) begin
        if (i_rx_vld) begin
          if (r_cnt == CNT_LAST) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end else if (i_read_start && i_rdy) begin
        r_active <= 1'b1;
        r_cnt    <= '0;
      end
    end
  end

  assign o_read_ena = r_read_ena;

endmodule

// File: rtl/gbt_rcv_checker.sv
// -----------------------------------------------------------------------------
// gbt_rcv_checker
// Receive-side checker for the GBT standalone test. Registers the raw receive
// word for the test points, locks onto the far-end incrementing counter
// pattern, counts mismatches while locked and generates read bursts.
//   CLK40 : 40 MHz clock
//   RST   : synchronous active-high reset
//   bus   : gbt_rcv_checker_if.slave (RX_DATA/RX_VLD/READ_START/ERR_CLR in;
//           GBT_RCV_DATA/_VLD, GBT_RCV_RDY, GBT_READ_ENA, ERR_CNT, LOCK_LOST,
//           STATE out)
// Optional: define GBT_RCV_CHK_FRAME_CNT_EN to add FRAME_CNT, a count of valid
// words received while locked.
// -----------------------------------------------------------------------------
module gbt_rcv_checker
  import gbt_chk_pkg::*;
#(
  parameter int LOCK_CNT   = LOCK_CNT_DEF,
  parameter int UNLOCK_CNT = UNLOCK_CNT_DEF,
  parameter int BURST_LEN  = BURST_LEN_DEF,
  parameter int ERR_W      = 16
) (
  input  logic               CLK40,
  input  logic               RST,
  gbt_rcv_checker_if.slave   bus
);

  localparam logic [1:0] S_HUNT   = HUNT;
  localparam logic [1:0] S_VERIFY = VERIFY;
  localparam logic [1:0] S_LOCKED = LOCKED;

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(UNLOCK_CNT + 1);

  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  logic [1:0]        r_state;
  gbt_word_t         r_exp;
  logic [GOOD_W-1:0] r_good;
  logic [MISS_W-1:0] r_miss;
  logic [ERR_W-1:0]  r_err;
  gbt_word_t         r_data;
  logic              r_vld;
  logic              r_rdy;
  logic              r_lost;

  logic [1:0]        w_state_nxt;
  gbt_word_t         w_exp_nxt;
  logic [GOOD_W-1:0] w_good_nxt;
  logic [MISS_W-1:0] w_miss_nxt;
  logic              w_err_inc;
  logic              w_lost;
  logic              w_match;
  logic              w_lock_nxt;
  gbt_word_t         w_rx_inc;
  gbt_word_t         w_exp_inc;
  logic [GOOD_W-1:0] w_good_inc;
  logic [MISS_W-1:0] w_miss_inc;
  logic              w_read_ena;

  assign w_match    = (bus.RX_DATA == r_exp);
  assign w_rx_inc   = bus.RX_DATA + 16'd1;   // 0xFFFF wraps to 0x0000
  assign w_exp_inc  = r_exp + 16'd1;
  assign w_good_inc = r_good + 1'b1;
  assign w_miss_inc = r_miss + 1'b1;

  // Next-state logic; nothing moves on cycles without a valid word.
  always_comb begin
    w_state_nxt = r_state;
    w_exp_nxt   = r_exp;
    w_good_nxt  = r_good;
    w_miss_nxt  = r_miss;
    w_err_inc   = 1'b0;
    w_lost      = 1'b0;
    if (bus.RX_VLD) begin
      case (r_state)
        S_HUNT: begin
          w_exp_nxt   = w_rx_inc;
          w_good_nxt  = GOOD_W'(1);
          w_state_nxt = S_VERIFY;
        end
        S_VERIFY: begin
          if (w_match) begin
            w_exp_nxt  = w_exp_inc;
            w_good_nxt = w_good_inc;
            if (w_good_inc == GOOD_W'(LOCK_CNT)) begin
              w_state_nxt = S_LOCKED;
              w_miss_nxt  = '0;
            end
          end else begin
            // Reseed from the word just seen; it becomes the first good word.
            w_exp_nxt  = w_rx_inc;
            w_good_nxt = GOOD_W'(1);
          end
        end
        S_LOCKED: begin
          // Expected value free-runs so isolated errors do not desynchronise.
          w_exp_nxt = w_exp_inc;
          if (w_match) begin
            w_miss_nxt = '0;
          end else begin
            w_miss_nxt = w_miss_inc;
            w_err_inc  = 1'b1;
            if (w_miss_inc == MISS_W'(UNLOCK_CNT)) begin
              w_state_nxt = S_HUNT;
              w_miss_nxt  = '0;
              w_lost      = 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt = S_HUNT;
        end
      endcase
    end
  end

  assign w_lock_nxt = (w_state_nxt == S_LOCKED);

  always_ff @(posedge CLK40) begin
    if (RST) begin
      r_state <= S_HUNT;
      r_exp   <= '0;
      r_good  <= '0;
      r_miss  <= '0;
      r_err   <= '0;
      r_data  <= '0;
      r_vld   <= 1'b0;
      r_rdy   <= 1'b0;
      r_lost  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_exp   <= w_exp_nxt;
      r_good  <= w_good_nxt;
      r_miss  <= w_miss_nxt;
      r_data  <= bus.RX_DATA;
      r_vld   <= bus.RX_VLD;
      r_rdy   <= w_lock_nxt;
      r_lost  <= w_lost;
      // A clear coinciding with an error leaves that error counted.
      if (w_err_inc) begin
        if (bus.ERR_CLR)          r_err <= ERR_W'(1);
        else if (r_err != ERR_MAX) r_err <= r_err + 1'b1;
      end else if (bus.ERR_CLR) begin
        r_err <= '0;
      end
    end
  end

  gbt_rd_burst #(
    .BURST_LEN (BURST_LEN)
  ) u_rd_burst (
    .i_clk        (CLK40),
    .i_rst        (RST),
    .i_rdy        (r_rdy),
    .i_lock_nxt   (w_lock_nxt),
    .i_read_start (bus.READ_START),
    .i_rx_vld     (bus.RX_VLD),
    .o_read_ena   (w_read_ena)
  );

`ifdef GBT_RCV_CHK_FRAME_CNT_EN
  logic [31:0] r_frame;

  always_ff @(posedge CLK40) begin
    if (RST) begin
      r_frame <= '0;
    end else if (w_state_nxt == S_HUNT) begin
      r_frame <= '0;
    end else if (bus.RX_VLD && (r_state == S_LOCKED)) begin
      r_frame <= r_frame + 32'd1;
    end
  end

  assign bus.FRAME_CNT = r_frame;
`endif

  assign bus.GBT_RCV_DATA     = r_data;
  assign bus.GBT_RCV_DATA_VLD = r_vld;
  assign bus.GBT_RCV_RDY      = r_rdy;
  assign bus.GBT_READ_ENA     = w_read_ena;
  assign bus.ERR_CNT          = r_err;
  assign bus.LOCK_LOST        = r_lost;
  assign bus.STATE            = r_state;

endmodule

// File: tb/tb_gbt_rcv_checker.sv
// -----------------------------------------------------------------------------
// tb_gbt_rcv_checker
// Directed bench for gbt_rcv_checker with a word-level reference model and a
// per-cycle compare process. Small thresholds (BURST_LEN=8, ERR_W=4) keep the
// burst and saturation cases short.
// -----------------------------------------------------------------------------
module tb_gbt_rcv_checker;
  import gbt_chk_pkg::*;

  localparam int LOCK   = 16;
  localparam int UNLOCK = 4;
  localparam int BLEN   = 8;
  localparam int EW     = 4;
  localparam int EMAX   = (1 << EW) - 1;

  // ---------------- clock / reset ----------------
  logic CLK40 = 1'b0;
  logic RST   = 1'b1;
  always #5 CLK40 = ~CLK40;

  gbt_rcv_checker_if #(.ERR_W(EW)) bus ();

  gbt_rcv_checker #(
    .LOCK_CNT   (LOCK),
    .UNLOCK_CNT (UNLOCK),
    .BURST_LEN  (BLEN),
    .ERR_W      (EW)
  ) dut (
    .CLK40 (CLK40),
    .RST   (RST),
    .bus   (bus)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (word level) ----------------
  bit          m_locked = 0;
  int          m_run    = 0;     // length of current matching run while unlocked
  logic [15:0] m_exp    = '0;
  int          m_miss   = 0;
  int          m_err    = 0;
  int          m_left   = 0;     // valid words remaining in burst
  logic [31:0] m_frame  = '0;
  logic [15:0] e_data   = '0;
  bit          e_vld    = 0;
  bit          e_rdy    = 0;
  bit          e_ena    = 0;
  bit          e_lost   = 0;

  always @(posedge CLK40) begin : model
    bit was_locked;
    bit was_active;
    bit inc;
    if (RST) begin
      m_locked = 0; m_run = 0; m_exp = '0; m_miss = 0; m_err = 0;
      m_left = 0; m_frame = '0;
      e_data = '0; e_vld = 0; e_rdy = 0; e_ena = 0; e_lost = 0;
    end else begin
      was_locked = m_locked;
      was_active = (m_left > 0);
      inc        = 0;
      e_lost     = 0;
      e_data     = bus.RX_DATA;
      e_vld      = bus.RX_VLD;
      if (bus.RX_VLD) begin
        if (!m_locked) begin
          if (m_run != 0 && bus.RX_DATA == m_exp) m_run++;
          else m_run = 1;
          m_exp = bus.RX_DATA + 16'd1;
          if (m_run == LOCK) begin
            m_locked = 1; m_run = 0; m_miss = 0;
          end
        end else begin
          m_frame++;
          if (bus.RX_DATA != m_exp) begin
            m_miss++;
            inc = 1;
          end else begin
            m_miss = 0;
          end
          m_exp++;
          if (m_miss == UNLOCK) begin
            m_locked = 0; m_miss = 0; m_run = 0; e_lost = 1; m_frame = '0;
          end
        end
      end
      if (inc) m_err = bus.ERR_CLR ? 1 : ((m_err < EMAX) ? m_err + 1 : EMAX);
      else if (bus.ERR_CLR) m_err = 0;
      if (!m_locked) begin
        m_left = 0;
        e_ena  = 0;
      end else begin
        e_ena = was_active && bus.RX_VLD;
        if (e_ena) m_left--;
        if (!was_active && bus.READ_START && was_locked) m_left = BLEN;
      end
      e_rdy = m_locked;
    end
  end

  // ---------------- compare process + output monitors ----------------
  int cnt_ena     = 0;
  int cnt_lost    = 0;
  int vld_seen    = 0;
  int rdy_rise_at = 0;
  bit rdy_prev    = 0;

  always @(negedge CLK40) begin
    check("rcv_data",  {16'd0, bus.GBT_RCV_DATA}, {16'd0, e_data});
    check("rcv_vld",   {31'd0, bus.GBT_RCV_DATA_VLD}, {31'd0, e_vld});
    check("rcv_rdy",   {31'd0, bus.GBT_RCV_RDY}, {31'd0, e_rdy});
    check("read_ena",  {31'd0, bus.GBT_READ_ENA}, {31'd0, e_ena});
    check("lock_lost", {31'd0, bus.LOCK_LOST}, {31'd0, e_lost});
    check("err_cnt",   32'(bus.ERR_CNT), 32'(m_err));
`ifdef GBT_RCV_CHK_FRAME_CNT_EN
    check("frame_cnt", bus.FRAME_CNT, m_frame);
`endif
    if (bus.GBT_READ_ENA === 1'b1) cnt_ena++;
    if (bus.LOCK_LOST === 1'b1) cnt_lost++;
    if (bus.GBT_RCV_DATA_VLD === 1'b1) vld_seen++;
    if (bus.GBT_RCV_RDY === 1'b1 && !rdy_prev) rdy_rise_at = vld_seen;
    rdy_prev = (bus.GBT_RCV_RDY === 1'b1);
  end

  // ---------------- driver tasks ----------------
  logic [15:0] seq = '0;

  task automatic drive(input logic [15:0] d, input bit v, input bit s, input bit c);
    @(posedge CLK40);
    #2;
    bus.RX_DATA    = d;
    bus.RX_VLD     = v;
    bus.READ_START = s;
    bus.ERR_CLR    = c;
  endtask

  task automatic good(input bit s = 0, input bit c = 0);
    drive(seq, 1'b1, s, c);
    seq = seq + 16'd1;
  endtask

  task automatic bad(input bit c = 0);
    drive(seq ^ 16'h8000, 1'b1, 1'b0, c);
    seq = seq + 16'd1;
  endtask

  task automatic idle(input bit s = 0);
    drive(16'h5A00 | 16'($urandom_range(0, 255)), 1'b0, s, 1'b0);
  endtask

  task automatic lock_from(input logic [15:0] b);
    seq = b;
    repeat (LOCK) good();
  endtask

  task automatic reset_dut(input int n);
    @(posedge CLK40);
    #2;
    RST = 1'b1;
    bus.RX_VLD = 1'b0; bus.READ_START = 1'b0; bus.ERR_CLR = 1'b0;
    repeat (n) @(posedge CLK40);
    #2;
    RST = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  int base_vld;
  int ena_base;
  int lost_base;

  initial begin
    bus.RX_DATA = '0; bus.RX_VLD = 1'b0; bus.READ_START = 1'b0; bus.ERR_CLR = 1'b0;

    // Reset state
    repeat (3) @(posedge CLK40);
    @(negedge CLK40);
    check("reset_rdy",  {31'd0, bus.GBT_RCV_RDY}, 32'd0);
    check("reset_err",  32'(bus.ERR_CNT), 32'd0);
    check("reset_data", {16'd0, bus.GBT_RCV_DATA}, 32'd0);
    #2 RST = 1'b0;

    // Clean lock: RDY rises with the 16th valid word on the outputs
    base_vld = vld_seen;
    lock_from(16'h1000);
    repeat (4) good();
    idle();
    @(negedge CLK40);
    check("lock_latency", 32'(rdy_rise_at - base_vld), 32'd16);
    check("lock_err", 32'(bus.ERR_CNT), 32'd0);

    // Wrap and gaps: lock at 0xFFF7, run through 0xFFFF->0x0000 with gaps
    reset_dut(2);
    seq = 16'hFFE8;
    repeat (28) begin
      good();
      idle();
    end
    @(negedge CLK40);
    check("wrap_rdy", {31'd0, bus.GBT_RCV_RDY}, 32'd1);
    check("wrap_err", 32'(bus.ERR_CNT), 32'd0);
    check("wrap_seq", {16'd0, seq}, 32'h0004);

    // Single error tolerated, then four in a row drop lock
    bad();
    repeat (3) good();
    idle();
    @(negedge CLK40);
    check("single_err", 32'(bus.ERR_CNT), 32'd1);
    check("single_rdy", {31'd0, bus.GBT_RCV_RDY}, 32'd1);
    lost_base = cnt_lost;
    repeat (4) bad();
    idle();
    idle();
    @(negedge CLK40);
    check("unlock_pulses", 32'(cnt_lost - lost_base), 32'd1);
    check("unlock_rdy", {31'd0, bus.GBT_RCV_RDY}, 32'd0);
    check("unlock_err", 32'(bus.ERR_CNT), 32'd5);

    // Burst at 50% duty, start while unlocked ignored, mid-burst start ignored
    reset_dut(2);
    ena_base = cnt_ena;
    idle(1);
    lock_from(16'h2000);
    idle();
    good(1);
    for (int i = 0; i < 12; i++) begin
      idle();
      good(i == 3);
    end
    idle();
    @(negedge CLK40);
    check("burst_len", 32'(cnt_ena - ena_base), 32'd8);

    // ERR_CLR coincident with an error, then plain clear
    good(); bad(); bad(); good();
    bad(1);
    idle();
    @(negedge CLK40);
    check("clr_coincident", 32'(bus.ERR_CNT), 32'd1);
    drive(16'h0000, 1'b0, 1'b0, 1'b1);
    idle();
    @(negedge CLK40);
    check("clr_plain", 32'(bus.ERR_CNT), 32'd0);

    // Lock loss mid-burst aborts READ_ENA together with RDY
    ena_base = cnt_ena;
    good(1);
    repeat (3) good();
    repeat (4) bad();
    idle();
    idle();
    @(negedge CLK40);
    check("abort_ena_cnt", 32'(cnt_ena - ena_base), 32'd6);
    check("abort_rdy", {31'd0, bus.GBT_RCV_RDY}, 32'd0);
    check("abort_err", 32'(bus.ERR_CNT), 32'd4);

    // Saturation: 20 errors, never more than 3 in a row
    lock_from(16'h3000);
    for (int i = 0; i < 20; i++) begin
      bad();
      if (i % 3 == 2) good();
    end
    idle();
    @(negedge CLK40);
    check("sat_err", 32'(bus.ERR_CNT), 32'd15);
    check("sat_rdy", {31'd0, bus.GBT_RCV_RDY}, 32'd1);

    // Reset mid-LOCKED with valid words still arriving
    good();
    @(posedge CLK40);
    #2 RST = 1'b1;
    @(posedge CLK40);
    #2 RST = 1'b0;
    bus.RX_VLD = 1'b0;
    @(negedge CLK40);
    check("rst_mid_rdy",  {31'd0, bus.GBT_RCV_RDY}, 32'd0);
    check("rst_mid_vld",  {31'd0, bus.GBT_RCV_DATA_VLD}, 32'd0);
    check("rst_mid_err",  32'(bus.ERR_CNT), 32'd0);
    check("rst_mid_data", {16'd0, bus.GBT_RCV_DATA}, 32'd0);
`ifdef GBT_RCV_CHK_FRAME_CNT_EN
    check("rst_mid_frame", bus.FRAME_CNT, 32'd0);
`endif

    idle();
    idle();
    @(negedge CLK40);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
